// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Single-outstanding request/response to APB3 requester.
//               Decodes the request address onto one of four slaves, runs
//               the SETUP/ACCESS handshake, muxes the selected slave's
//               PRDATA/PREADY and returns read data or an error. A bounded
//               ACCESS phase keeps a stuck slave from hanging the requester.
//
// Ports       : PCLK, PRESET                  clock, async active-high reset
//               req_valid/write/addr/wdata    request from the CPU side
//               req_ready                     high while idle (accept edge)
//               rsp_valid/rdata/err           one-cycle response pulse
//               PADDR/PWRITE/PWDATA           APB request fields
//               PSEL[3:0], PENABLE            APB select (one-hot) / enable
//               PRDATA0..3, PREADY0..3        per-slave return path
//
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter logic [15:0] BASE_HI = 16'h1000,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    // Counter holds up to TIMEOUT so the increment on the abort cycle cannot wrap.
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [1:0]         r_idx;
    logic [c_CNT_W-1:0] r_cnt;

    logic        w_mapped;
    logic        w_accept;
    logic        w_pready_sel;
    logic [31:0] w_prdata_sel;
    logic        w_done;
    logic        w_timeout;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_mapped  = (req_addr[31:16] == BASE_HI) && (req_addr[15:14] == 2'b00);
    assign req_ready = (r_state == c_ST_IDLE);
    assign w_accept  = req_valid && req_ready;

    // Only the latched slave's return path is ever looked at.
    always_comb begin
        w_pready_sel = 1'b0;
        w_prdata_sel = '0;
        case (r_idx)
            2'd0:    begin w_pready_sel = PREADY0; w_prdata_sel = PRDATA0; end
            2'd1:    begin w_pready_sel = PREADY1; w_prdata_sel = PRDATA1; end
            2'd2:    begin w_pready_sel = PREADY2; w_prdata_sel = PRDATA2; end
            default: begin w_pready_sel = PREADY3; w_prdata_sel = PRDATA3; end
        endcase
    end

    assign w_done    = (r_state == c_ST_ACCESS) && w_pready_sel;
    // A ready on the last allowed cycle wins over the abort.
    assign w_timeout = (r_state == c_ST_ACCESS) && !w_pready_sel &&
                       (r_cnt == c_CNT_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // Unmapped requests never leave IDLE; they are answered directly.
                if (w_accept && w_mapped) begin
                    w_state_nxt = c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                w_state_nxt = c_ST_ACCESS;
            end
            c_ST_ACCESS: begin
                if (w_done || w_timeout) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // APB request fields: captured at acceptance, held until the next one
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            PADDR  <= req_addr;
            PWRITE <= req_write;
            PWDATA <= req_wdata;
            r_idx  <= req_addr[13:12];
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_psel
            assign PSEL[gi] = (r_state != c_ST_IDLE) && (r_idx == 2'(gi));
        end
    endgenerate

    assign PENABLE = (r_state == c_ST_ACCESS);

    // ------------------------------------------------------------------
    // ACCESS-phase wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_cnt <= '0;
        end else if (r_state == c_ST_SETUP) begin
            r_cnt <= '0;
        end else if ((r_state == c_ST_ACCESS) && !w_pready_sel) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Response: a one-cycle pulse, data is zero unless a read completed
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (w_accept && !w_mapped) || w_done || w_timeout;
            rsp_err   <= (w_accept && !w_mapped) || w_timeout;
            rsp_rdata <= (w_done && !PWRITE) ? w_prdata_sel : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Self-checking bench for apb_master_bridge. A transaction
//               timeline model predicts every output each cycle from the
//               accept edge, the slave wait count and the timeout limit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err, PWRITE, PENABLE;
    logic [31:0] rsp_rdata, PADDR, PWDATA;
    logic [3:0]  PSEL;
    logic [31:0] pd [4];
    logic        pr [4];

    apb_master_bridge #(.BASE_HI(16'h1000), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA0(pd[0]), .PRDATA1(pd[1]), .PRDATA2(pd[2]), .PRDATA3(pd[3]),
        .PREADY0(pr[0]), .PREADY1(pr[1]), .PREADY2(pr[2]), .PREADY3(pr[3])
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model state ----------------
    int          n = 0;          // edges since start
    bit          m_ready = 1'b1; // model's view of req_ready in the current cycle
    bit          act = 1'b0;
    int          A = 0;          // accept edge of current transaction
    bit          t_mapped, t_wr;
    int          t_idx, t_waits;
    logic [31:0] t_rdata;
    logic [31:0] e_paddr = '0, e_pwdata = '0;
    logic        e_pwrite = 1'b0;
    int          acc_cnt = 0, acc_n = 0;
    int          pen_cnt = 0, psel_cnt = 0;
    int          last_rsp_n = 0;
    logic        last_err = 1'b0;
    logic [31:0] last_rdata = '0;
    int          p_waits = 0;    // wait states the slave will insert for the pending request
    logic [31:0] p_rdata = '0;

    // Model + per-cycle compare
    initial begin
        forever begin
            @(posedge PCLK);
            if (PRESET) begin
                act = 1'b0; m_ready = 1'b1;
                e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0;
                continue;
            end
            n++;
            if (req_valid && m_ready) begin
                act = 1'b1; A = n;
                t_wr = req_write;
                t_mapped = (req_addr[31:16] == 16'h1000) && (req_addr[15:14] == 2'b00);
                t_idx = int'(req_addr[13:12]);
                t_waits = p_waits; t_rdata = p_rdata;
                e_paddr = req_addr; e_pwrite = req_write; e_pwdata = req_wdata;
                acc_cnt++; acc_n = n; pen_cnt = 0; psel_cnt = 0;
            end
            #1;
            begin
                int d, w;
                bit to;
                logic [3:0]  e_psel;
                bit          e_pen, e_rv, e_err, e_rdy;
                logic [31:0] e_rd;
                e_psel = '0; e_pen = 0; e_rv = 0; e_err = 0; e_rd = '0; e_rdy = 1;
                if (act) begin
                    d  = n - A;
                    to = (t_waits >= TIMEOUT);
                    w  = to ? TIMEOUT - 1 : t_waits;   // wait cycles actually spent
                    if (t_mapped) begin
                        if (d <= 1 + w) begin
                            e_psel = 4'b0001 << t_idx;
                            e_pen  = (d >= 1);
                            e_rdy  = 0;
                        end else if (d == 2 + w) begin
                            e_rv = 1; e_err = to;
                            e_rd = (t_wr || to) ? 32'h0 : t_rdata;
                        end
                    end else if (d == 0) begin
                        e_rv = 1; e_err = 1;
                    end
                end
                m_ready = e_rdy;
                chk("req_ready", {31'b0, req_ready}, {31'b0, e_rdy});
                chk("PSEL",      {28'b0, PSEL},      {28'b0, e_psel});
                chk("PENABLE",   {31'b0, PENABLE},   {31'b0, e_pen});
                chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
                if (e_rv) begin
                    chk("rsp_err",   {31'b0, rsp_err}, {31'b0, e_err});
                    chk("rsp_rdata", rsp_rdata, e_rd);
                end
                chk("PADDR",  PADDR, e_paddr);
                chk("PWRITE", {31'b0, PWRITE}, {31'b0, e_pwrite});
                chk("PWDATA", PWDATA, e_pwdata);
            end
            if (PENABLE) pen_cnt++;
            if (PSEL != 4'b0) psel_cnt++;
            if (rsp_valid) begin
                last_rsp_n = n; last_err = rsp_err; last_rdata = rsp_rdata;
            end
        end
    end

    // Slave stimulus: non-selected slaves are always ready with junk data;
    // the selected slave is ready in SETUP (must be ignored) and after its waits.
    always @(negedge PCLK) begin
        for (int i = 0; i < 4; i++) begin
            pr[i] = 1'b1;
            pd[i] = 32'hFFFF_FFFF;
        end
        if (act && t_mapped) begin
            pr[t_idx] = ((n - A) == 0) || ((n - A) == 1 + t_waits);
            pd[t_idx] = ((n - A) == 1 + t_waits) ? t_rdata : 32'hBAD0_0000 + 32'(n - A);
        end
    end

    // Caller is at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic [31:0] rd, input bit hold);
        int k0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        p_waits = waits; p_rdata = rd;
        k0 = acc_cnt;
        for (int i = 0; i < 200 && acc_cnt == k0; i++) @(negedge PCLK);
        if (acc_cnt == k0) begin
            errors++; checks++;
            $display("FAIL accept_wait: got no accept expected accept within 200 cycles");
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = m_ready;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge PCLK);
            ok = m_ready;
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL done_wait: got busy expected idle within 100 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge PCLK);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_PSEL",      {28'b0, PSEL},      32'd0);
        chk("rst_PENABLE",   {31'b0, PENABLE},   32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_PADDR",     PADDR, 32'd0);
        chk("rst_PWDATA",    PWDATA, 32'd0);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);

        // Write to slave 1, ready one cycle into ACCESS
        issue(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
        wait_done();
        chk("t1_pen_cycles",  pen_cnt, 32'd2);
        chk("t1_psel_cycles", psel_cnt, 32'd3);
        chk("t1_latency",     last_rsp_n - acc_n, 32'd3);
        chk("t1_err",         {31'b0, last_err}, 32'd0);
        @(negedge PCLK);

        // Read from slave 2 with two wait states
        issue(1'b0, 32'h1000_2008, 32'h0, 2, 32'h1234_5678, 1'b0);
        wait_done();
        chk("t2_rdata",       last_rdata, 32'h1234_5678);
        chk("t2_latency",     last_rsp_n - acc_n, 32'd4);
        chk("t2_psel_cycles", psel_cnt, 32'd4);
        chk("t2_err",         {31'b0, last_err}, 32'd0);
        @(negedge PCLK);

        // Unmapped: wrong high half, then window beyond slave 3
        issue(1'b0, 32'h2000_0000, 32'h0, 0, 32'h0, 1'b0);
        wait_done();
        chk("t3a_err",     {31'b0, last_err}, 32'd1);
        chk("t3a_rdata",   last_rdata, 32'd0);
        chk("t3a_latency", last_rsp_n - acc_n, 32'd0);
        chk("t3a_psel",    psel_cnt, 32'd0);
        @(negedge PCLK);
        issue(1'b0, 32'h1000_4000, 32'h0, 0, 32'h0, 1'b0);
        wait_done();
        chk("t3b_err",  {31'b0, last_err}, 32'd1);
        chk("t3b_psel", psel_cnt, 32'd0);
        @(negedge PCLK);

        // Slave 3 never ready -> timeout after 16 ACCESS cycles
        issue(1'b0, 32'h1000_3000, 32'h0, 1000, 32'h0, 1'b0);
        wait_done();
        chk("t4a_pen_cycles", pen_cnt, 32'd16);
        chk("t4a_err",        {31'b0, last_err}, 32'd1);
        chk("t4a_rdata",      last_rdata, 32'd0);
        @(negedge PCLK);
        // Ready on the 16th ACCESS cycle completes normally
        issue(1'b0, 32'h1000_3000, 32'h0, 15, 32'hA5A5_0003, 1'b0);
        wait_done();
        chk("t4b_pen_cycles", pen_cnt, 32'd16);
        chk("t4b_err",        {31'b0, last_err}, 32'd0);
        chk("t4b_rdata",      last_rdata, 32'hA5A5_0003);
        @(negedge PCLK);

        // Back-to-back: second request held valid while the first is busy
        issue(1'b1, 32'h1000_1004, 32'h0BAD_F00D, 1, 32'h0, 1'b1);
        issue(1'b0, 32'h1000_0000, 32'h0, 0, 32'h0000_C0DE, 1'b0);
        chk("t5_accept_on_rsp", acc_n - last_rsp_n, 32'd1);
        wait_done();
        chk("t5_rdata", last_rdata, 32'h0000_C0DE);
        @(negedge PCLK);

        // Reset in the middle of ACCESS
        issue(1'b0, 32'h1000_3000, 32'h0, 1000, 32'h0, 1'b0);
        repeat (3) @(negedge PCLK);
        #2 PRESET = 1'b1;
        #1;
        chk("t6_async_PSEL",    {28'b0, PSEL},      32'd0);
        chk("t6_async_PENABLE", {31'b0, PENABLE},   32'd0);
        chk("t6_async_rsp",     {31'b0, rsp_valid}, 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        repeat (3) @(negedge PCLK);
        issue(1'b1, 32'h1000_0010, 32'hCAFE_F00D, 0, 32'h0, 1'b0);
        wait_done();
        chk("t6_post_err",     {31'b0, last_err}, 32'd0);
        chk("t6_post_latency", last_rsp_n - acc_n, 32'd2);
        repeat (3) @(negedge PCLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
